// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer logic (write and read sides).
// Functions work on 32-bit containers and take the live width as an argument.
// Results are masked to that width, so callers cast back to their pointer width.
package fifo_pkg;

  localparam int DEEP_DEFAULT = 8;

  function automatic logic [31:0] width_mask(input int unsigned w);
    return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned w);
    logic [31:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  // Prefix XOR from the MSB down, done by doubling shift distances.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
    logic [31:0] b;
    b = g & width_mask(w);
    for (int s = 1; s < 32; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

  // The FIFO is full when the write pointer is exactly one lap ahead of the read pointer.
  // In Gray code that means the top two bits are inverted and the rest are equal.
  function automatic logic full_cmp(input logic [31:0] wg, input logic [31:0] rq,
                                    input int unsigned w);
    logic [31:0] m;
    m = width_mask(w);
    return (wg & m) == ((rq ^ (32'h3 << (w - 2))) & m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for Gray pointers crossing into the clk_in domain.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk_in,
  input  logic         arst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // No logic sits between the input and the first flop; the source must be a registered Gray value.
  always_ff @(posedge clk_in or posedge arst) begin
    if (arst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for the dual-clock FIFO. It qualifies pushes and owns the
// Gray write pointer. It also derives full, almost-full, fill level and sticky overflow.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int          DEEP     = DEEP_DEFAULT,
  parameter int unsigned AF_LEVEL = (1 << DEEP) - 2
) (
  input  logic            clk_in,
  input  logic            arst,
  input  logic            push,
  input  logic [DEEP:0]   rptr_gray,
  input  logic            ovf_clr,
  output logic [DEEP:0]   address_w,
  output logic            w_en,
  output logic            wr_full,
  output logic            wr_almost_full,
  output logic [DEEP:0]   wr_level,
  output logic            wr_overflow
);

  localparam int PW = DEEP + 1;

  logic [PW-1:0] wbin_q,  wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] lvl_q,   lvl_d;
  logic          full_q,  full_d;
  logic          af_q,    af_d;
  logic          ovf_q,   ovf_d;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rbin;

  sync_2ff #(.W(PW)) u_rptr_sync (
    .clk_in (clk_in),
    .arst   (arst),
    .d_i    (rptr_gray),
    .q_o    (rq2)
  );

  // A push is only accepted while the registered full flag is low.
  assign w_en = push & ~full_q;

  // Next pointers plus flags evaluated on the post-write pointer, so full lands on the filling edge.
  always_comb begin
    wbin_d  = wbin_q + {{(PW-1){1'b0}}, w_en};
    wgray_d = PW'(bin2gray(32'(wbin_d), PW));
    rbin    = PW'(gray2bin(32'(rq2), PW));
    lvl_d   = wbin_d - rbin;
    full_d  = full_cmp(32'(wgray_d), 32'(rq2), PW);
    af_d    = (32'(lvl_d) >= AF_LEVEL);
    ovf_d   = ovf_q;
    if (push && full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Pointer and status registers; reset drops everything so both sides restart at zero together.
  always_ff @(posedge clk_in or posedge arst) begin
    if (arst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      lvl_q   <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      lvl_q   <= lvl_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  assign address_w      = wgray_q;
  assign wr_full        = full_q;
  assign wr_almost_full = af_q;
  assign wr_level       = lvl_q;
  assign wr_overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl with DEEP=3 and AF_LEVEL=6.
// The reference model counts writes and reads as plain integers.
// The read count reaches the level/full decision two clk_in edges late.
module tb_fifo_wr_ctrl;

  logic       clk_in = 1'b0;
  logic       arst;
  logic       push;
  logic       ovf_clr;
  logic [3:0] rptr_gray;
  logic [3:0] address_w;
  logic       w_en;
  logic       wr_full;
  logic       wr_almost_full;
  logic [3:0] wr_level;
  logic       wr_overflow;

  int n_cmp = 0;
  int n_err = 0;
  int rcnt;

  // model state
  int m_w, m_lvl, s1, s2, nw, lvl;
  bit m_full, m_af, m_ovf, acc;

  fifo_wr_ctrl #(.DEEP(3), .AF_LEVEL(6)) dut (
    .clk_in         (clk_in),
    .arst           (arst),
    .push           (push),
    .rptr_gray      (rptr_gray),
    .ovf_clr        (ovf_clr),
    .address_w      (address_w),
    .w_en           (w_en),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .wr_level       (wr_level),
    .wr_overflow    (wr_overflow)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [3:0] gray4(input int n);
    int m;
    m = n % 16;
    return 4'(m ^ (m >> 1));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_r(input int n);
    rcnt      = n;
    rptr_gray = gray4(n);
  endtask

  task automatic edge1;
    @(posedge clk_in);
    #1;
  endtask

  // Behavioural model: occupancy is writes minus reads-as-seen, full is occupancy == 8
  always @(posedge clk_in or posedge arst) begin
    if (arst) begin
      m_w = 0; m_lvl = 0; s1 = 0; s2 = 0;
      m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      acc   = push && !m_full;
      nw    = m_w + (acc ? 1 : 0);
      lvl   = nw - s2;
      if (push && m_full) m_ovf = 1;
      else if (ovf_clr)   m_ovf = 0;
      m_full = (lvl == 8);
      m_af   = (lvl >= 6);
      m_lvl  = lvl;
      s2     = s1;
      s1     = rcnt;
      m_w    = nw;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk_in) begin
    if (!arst) begin
      chk("m_addr",  address_w,      gray4(m_w));
      chk("m_wen",   w_en,           (push && !m_full) ? 1 : 0);
      chk("m_full",  wr_full,        m_full);
      chk("m_af",    wr_almost_full, m_af);
      chk("m_level", wr_level,       m_lvl);
      chk("m_ovf",   wr_overflow,    m_ovf);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gseq [8];
    int bw, prevw, accn;
    gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4};

    arst = 1'b1; push = 1'b0; ovf_clr = 1'b0;
    set_r(0);
    #1;
    chk("rst_addr",  address_w, 0);
    chk("rst_full",  wr_full, 0);
    chk("rst_level", wr_level, 0);
    chk("rst_af",    wr_almost_full, 0);
    chk("rst_ovf",   wr_overflow, 0);
    chk("rst_wen",   w_en, 0);
    #11 arst = 1'b0;
    edge1();

    // 1: eight pushes from empty
    for (int i = 0; i < 8; i++) begin
      push = 1'b1;
      #1;
      chk("t1_addr", address_w, gseq[i]);
      chk("t1_wen",  w_en, 1);
      edge1();
      if (i == 4) chk("t1_af_low", wr_almost_full, 0);
      if (i == 5) chk("t1_af_high", wr_almost_full, 1);
      if (i < 7)  chk("t1_not_full", wr_full, 0);
    end
    chk("t1_addr_end", address_w, 12);
    chk("t1_full", wr_full, 1);
    chk("t1_level", wr_level, 8);

    // 2: push while full, then clear, then clear racing a dropped push
    #1;
    chk("t2_wen", w_en, 0);
    edge1();
    chk("t2_addr_hold", address_w, 12);
    chk("t2_ovf_set", wr_overflow, 1);
    push = 1'b0; ovf_clr = 1'b1;
    edge1();
    chk("t2_ovf_clr", wr_overflow, 0);
    push = 1'b1; ovf_clr = 1'b1;
    edge1();
    chk("t2_set_wins", wr_overflow, 1);
    chk("t2_addr_hold2", address_w, 12);
    push = 1'b0; ovf_clr = 1'b0;

    // 3: one read, full drops on the third edge
    set_r(1);
    edge1();
    chk("t3_full_e1", wr_full, 1);
    edge1();
    chk("t3_full_e2", wr_full, 1);
    edge1();
    chk("t3_full_e3", wr_full, 0);
    chk("t3_level", wr_level, 7);
    ovf_clr = 1'b1;
    edge1();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", wr_overflow, 0);

    // 4: drain, then 20 pushes with the reader one cycle behind, crossing the wrap
    set_r(8);
    edge1(); edge1(); edge1();
    chk("t4_empty", wr_level, 0);
    bw = 8; prevw = 8;
    for (int i = 0; i < 20; i++) begin
      push = 1'b1;
      set_r(prevw);
      prevw = bw;
      #1;
      chk("t4_wen", w_en, 1);
      edge1();
      bw++;
      chk("t4_no_full", wr_full, 0);
      chk("t4_lvl_le4", (wr_level <= 4) ? 1 : 0, 1);
      if (bw % 16 == 15) chk("t4_addr_b15", address_w, 8);
      if (bw % 16 == 0)  chk("t4_addr_b16", address_w, 0);
    end
    push = 1'b0;
    set_r(bw);
    edge1(); edge1(); edge1();
    chk("t4_drained", wr_level, 0);

    // 5: asynchronous reset between edges after five pushes
    for (int i = 0; i < 5; i++) begin
      push = 1'b1;
      edge1();
    end
    push = 1'b0;
    #2 arst = 1'b1;
    #1;
    chk("t5_addr",  address_w, 0);
    chk("t5_full",  wr_full, 0);
    chk("t5_level", wr_level, 0);
    chk("t5_af",    wr_almost_full, 0);
    chk("t5_ovf",   wr_overflow, 0);
    chk("t5_wen",   w_en, 0);
    set_r(0);
    #3 arst = 1'b0;
    push = 1'b1;
    #1;
    chk("t5_first_addr", address_w, 0);
    chk("t5_first_wen",  w_en, 1);
    edge1();
    chk("t5_next_addr", address_w, 1);

    // 6: fill, hold push while full, reader jumps by two
    for (int i = 0; i < 7; i++) edge1();
    chk("t6_full", wr_full, 1);
    chk("t6_ovf_before", wr_overflow, 0);
    edge1();
    chk("t6_ovf_after", wr_overflow, 1);
    set_r(2);
    accn = 0;
    for (int k = 0; k < 8; k++) begin
      if (w_en) accn++;
      edge1();
    end
    chk("t6_accepted", accn, 2);
    chk("t6_full_end", wr_full, 1);
    chk("t6_level_end", wr_level, 8);
    chk("t6_ovf_end", wr_overflow, 1);
    chk("t6_addr_end", address_w, 15);
    push = 1'b0;
    edge1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
